// File: rtl/keccak_feeder.sv
// keccak_feeder: collects padded 64-bit host words into rate-sized blocks
// and streams each complete block to a Keccak core.
module keccak_feeder #(
    parameter int MAXW = 21
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [2:0]  cfg_mode,
    input  logic [10:0] cfg_d,
    input  logic        msg_start,
    input  logic [63:0] msg_data,
    input  logic        msg_valid,
    input  logic        msg_last,
    output logic        msg_ready,
    output logic        start,
    output logic [63:0] dt_i,
    output logic [2:0]  cmode,
    output logic [10:0] d,
    output logic        last_block,
    input  logic        valid,
    input  logic        ready,
    output logic        busy,
    output logic        done,
    output logic        err
);
    typedef enum logic [1:0] {IDLE, FILL, SEND, WAIT_HASH} state_t;

    state_t      state_q, state_d;
    logic [4:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, rate;
    logic [2:0]  cmode_q, cmode_d;
    logic [10:0] d_q, d_d;
    logic        start_q, start_d, last_q, last_d, err_q, err_d, done_q, done_d, wr_en;
    logic [63:0] mem_q [MAXW];

    assign rate = cmode_q == 3'd0 ? 5'd18 :
                  cmode_q == 3'd1 ? 5'd17 :
                  cmode_q == 3'd2 ? 5'd13 :
                  cmode_q == 3'd3 ? 5'd9  :
                  cmode_q == 3'd4 ? 5'd21 : 5'd17;

    // wr_ptr stops on the index of the final written word, so words beyond it
    // in a short block read back as zero without clearing the buffer.
    always_comb begin
        state_d  = state_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cmode_d  = cmode_q;
        d_d      = d_q;
        start_d  = 1'b0;
        last_d   = last_q;
        err_d    = err_q;
        done_d   = 1'b0;
        wr_en    = 1'b0;
        case (state_q)
            IDLE: if (msg_start) begin
                if (cfg_mode < 3'd6) begin
                    cmode_d  = cfg_mode;
                    d_d      = cfg_d;
                    err_d    = 1'b0;
                    start_d  = 1'b1;
                    wr_ptr_d = 5'd0;
                    rd_ptr_d = 5'd0;
                    state_d  = FILL;
                end else begin
                    err_d = 1'b1;
                end
            end
            FILL: if (msg_valid) begin
                wr_en = 1'b1;
                if (wr_ptr_q == rate - 5'd1 || msg_last) begin
                    last_d   = msg_last;
                    rd_ptr_d = 5'd0;
                    state_d  = SEND;
                    if (wr_ptr_q != rate - 5'd1) err_d = 1'b1;
                end else begin
                    wr_ptr_d = wr_ptr_q + 5'd1;
                end
            end
            SEND: if (valid) begin
                if (rd_ptr_q == rate - 5'd1) begin
                    rd_ptr_d = 5'd0;
                    wr_ptr_d = 5'd0;
                    state_d  = last_q ? WAIT_HASH : FILL;
                end else begin
                    rd_ptr_d = rd_ptr_q + 5'd1;
                end
            end
            WAIT_HASH: if (ready) begin
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            wr_ptr_q <= 5'd0;
            rd_ptr_q <= 5'd0;
            cmode_q  <= 3'd0;
            d_q      <= 11'd0;
            start_q  <= 1'b0;
            last_q   <= 1'b0;
            err_q    <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cmode_q  <= cmode_d;
            d_q      <= d_d;
            start_q  <= start_d;
            last_q   <= last_d;
            err_q    <= err_d;
            done_q   <= done_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_ptr_q] <= msg_data;
    end

    assign msg_ready  = state_q == FILL;
    assign start      = start_q;
    assign dt_i       = (state_q == SEND && rd_ptr_q <= wr_ptr_q) ? mem_q[rd_ptr_q] : 64'd0;
    assign cmode      = cmode_q;
    assign d          = d_q;
    assign last_block = state_q == SEND && last_q;
    assign busy       = state_q != IDLE;
    assign done       = done_q;
    assign err        = err_q;
endmodule

// File: tb/tb_keccak_feeder.sv
// tb_keccak_feeder: directed messages checked every cycle against a
// block-level queue model, plus literal expectations on the streamed words.
module tb_keccak_feeder;
    logic        clk = 1'b0, rst_n = 1'b1;
    logic [2:0]  cfg_mode = 3'd0;
    logic [10:0] cfg_d = 11'd0;
    logic        msg_start = 1'b0, msg_valid = 1'b0, msg_last = 1'b0, valid = 1'b0, ready = 1'b0;
    logic [63:0] msg_data = 64'd0;
    logic        msg_ready, start, last_block, busy, done, err;
    logic [63:0] dt_i;
    logic [2:0]  cmode;
    logic [10:0] d;
    int n_checks = 0, n_fail = 0, n_start = 0, n_done = 0;

    keccak_feeder dut (
        .clk(clk), .rst_n(rst_n), .cfg_mode(cfg_mode), .cfg_d(cfg_d),
        .msg_start(msg_start), .msg_data(msg_data), .msg_valid(msg_valid),
        .msg_last(msg_last), .msg_ready(msg_ready), .start(start), .dt_i(dt_i),
        .cmode(cmode), .d(d), .last_block(last_block), .valid(valid),
        .ready(ready), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: phase 0 idle, 1 collecting words, 2 streaming a block, 3 awaiting hash.
    int          rate_tbl [6] = '{18, 17, 13, 9, 21, 17};
    int          m_phase = 0, m_rate = 0;
    logic [63:0] cur[$], blk[$];
    logic        m_last = 1'b0, m_err = 1'b0, m_start = 1'b0, m_done = 1'b0;
    logic [2:0]  m_cmode = 3'd0;
    logic [10:0] m_d = 11'd0;

    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            m_phase = 0; m_last = 1'b0; m_err = 1'b0; m_start = 1'b0; m_done = 1'b0;
            m_cmode = 3'd0; m_d = 11'd0;
            cur.delete(); blk.delete();
        end else begin
            m_start = 1'b0;
            m_done  = 1'b0;
            case (m_phase)
                0: if (msg_start) begin
                    if (cfg_mode < 3'd6) begin
                        m_cmode = cfg_mode; m_d = cfg_d; m_err = 1'b0; m_start = 1'b1;
                        m_rate = rate_tbl[cfg_mode];
                        cur.delete();
                        m_phase = 1;
                    end else m_err = 1'b1;
                end
                1: if (msg_valid) begin
                    cur.push_back(msg_data);
                    if (cur.size() == m_rate || msg_last) begin
                        if (cur.size() < m_rate) m_err = 1'b1;
                        while (cur.size() < m_rate) cur.push_back(64'd0);
                        blk = cur;
                        cur.delete();
                        m_last = msg_last;
                        m_phase = 2;
                    end
                end
                2: if (valid) begin
                    void'(blk.pop_front());
                    if (blk.size() == 0) m_phase = m_last ? 3 : 1;
                end
                3: if (ready) begin
                    m_done = 1'b1;
                    m_phase = 0;
                end
                default: m_phase = 0;
            endcase
        end
    end

    logic [63:0] seen[$];
    logic        seen_lb[$];

    initial forever begin
        @(negedge clk);
        chk("msg_ready", 64'(msg_ready), 64'(m_phase == 1));
        chk("start", 64'(start), 64'(m_start));
        chk("dt_i", dt_i, m_phase == 2 ? blk[0] : 64'd0);
        chk("cmode", 64'(cmode), 64'(m_cmode));
        chk("d", 64'(d), 64'(m_d));
        chk("last_block", 64'(last_block), 64'(m_phase == 2 && m_last));
        chk("busy", 64'(busy), 64'(m_phase != 0));
        chk("done", 64'(done), 64'(m_done));
        chk("err", 64'(err), 64'(m_err));
        if (start) n_start++;
        if (done) n_done++;
        if (valid && m_phase == 2) begin
            seen.push_back(dt_i);
            seen_lb.push_back(last_block);
        end
    end

    function automatic logic [63:0] sw(input int i);
        return i < seen.size() ? seen[i] : 64'hDEAD_BEEF;
    endfunction

    function automatic logic slb(input int i);
        return i < seen_lb.size() ? seen_lb[i] : 1'bx;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic begin_msg(input logic [2:0] m, input logic [10:0] dl);
        cfg_mode = m; cfg_d = dl; msg_start = 1'b1;
        tick();
        msg_start = 1'b0;
    endtask

    task automatic put(input logic [63:0] w, input logic l);
        msg_valid = 1'b1; msg_data = w; msg_last = l;
        tick();
        msg_valid = 1'b0; msg_last = 1'b0;
    endtask

    task automatic consume(input int n, input logic toggle);
        int k = 0;
        for (int c = 0; c < 4 * n && k < n; c++) begin
            valid = toggle ? (c % 2 == 0) : 1'b1;
            if (valid) k++;
            tick();
        end
        valid = 1'b0;
    endtask

    task automatic finish_hash();
        ready = 1'b1;
        tick();
        ready = 1'b0;
        tick();
        tick();
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_msg_ready"}, 64'(msg_ready), 64'd0);
        chk({tag, "_start"}, 64'(start), 64'd0);
        chk({tag, "_dt_i"}, dt_i, 64'd0);
        chk({tag, "_cmode"}, 64'(cmode), 64'd0);
        chk({tag, "_d"}, 64'(d), 64'd0);
        chk({tag, "_last_block"}, 64'(last_block), 64'd0);
        chk({tag, "_busy"}, 64'(busy), 64'd0);
        chk({tag, "_done"}, 64'(done), 64'd0);
        chk({tag, "_err"}, 64'(err), 64'd0);
    endtask

    initial begin
        int s0, d0, bad;
        #1 rst_n = 1'b0;
        tick(); tick();
        check_reset_outputs("rst");
        rst_n = 1'b1;
        tick();

        // SHA3-512, one block of 9 words.
        seen.delete(); seen_lb.delete(); s0 = n_start; d0 = n_done;
        begin_msg(3'd3, 11'd512);
        for (int i = 1; i <= 9; i++) put(64'(i), i == 9);
        consume(9, 1'b0);
        finish_hash();
        chk("A_count", 64'(seen.size()), 64'd9);
        for (int i = 0; i < 9; i++) chk("A_word", sw(i), 64'(i + 1));
        chk("A_lb_first", 64'(slb(0)), 64'd1);
        chk("A_lb_last", 64'(slb(8)), 64'd1);
        chk("A_starts", 64'(n_start - s0), 64'd1);
        chk("A_dones", 64'(n_done - d0), 64'd1);
        chk("A_cmode", 64'(cmode), 64'd3);
        chk("A_d", 64'(d), 64'd512);

        // Illegal mode.
        s0 = n_start;
        begin_msg(3'd7, 11'd100);
        tick();
        chk("D_err", 64'(err), 64'd1);
        chk("D_busy", 64'(busy), 64'd0);
        chk("D_starts", 64'(n_start - s0), 64'd0);

        // SHAKE256, two blocks of 17 words.
        seen.delete(); seen_lb.delete(); d0 = n_done;
        begin_msg(3'd5, 11'd256);
        chk("B_err_cleared", 64'(err), 64'd0);
        for (int i = 0; i < 17; i++) put(64'(100 + i), 1'b0);
        consume(17, 1'b0);
        for (int i = 17; i < 34; i++) put(64'(100 + i), i == 33);
        consume(17, 1'b0);
        finish_hash();
        chk("B_count", 64'(seen.size()), 64'd34);
        bad = 0;
        for (int i = 0; i < 34; i++) if (sw(i) !== 64'(100 + i)) bad++;
        chk("B_words_bad", 64'(bad), 64'd0);
        chk("B_lb0", 64'(slb(0)), 64'd0);
        chk("B_lb16", 64'(slb(16)), 64'd0);
        chk("B_lb17", 64'(slb(17)), 64'd1);
        chk("B_lb33", 64'(slb(33)), 64'd1);
        chk("B_dones", 64'(n_done - d0), 64'd1);

        // Early msg_last on word 5 of a 9-word block.
        seen.delete(); seen_lb.delete();
        begin_msg(3'd3, 11'd512);
        for (int i = 1; i <= 5; i++) put(64'hC0 + 64'(i), i == 5);
        consume(9, 1'b0);
        chk("C_err", 64'(err), 64'd1);
        finish_hash();
        chk("C_count", 64'(seen.size()), 64'd9);
        chk("C_word5", sw(4), 64'hC5);
        for (int i = 5; i < 9; i++) chk("C_zero", sw(i), 64'd0);
        chk("C_lb6", 64'(slb(5)), 64'd1);

        // Asynchronous reset while the fourth word is on dt_i.
        d0 = n_done;
        begin_msg(3'd3, 11'd384);
        for (int i = 1; i <= 9; i++) put(64'h50 + 64'(i), i == 9);
        valid = 1'b1;
        tick(); tick(); tick();
        chk("E_word4", dt_i, 64'h54);
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("E");
        valid = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (4) tick();
        chk("E_no_done", 64'(n_done - d0), 64'd0);

        // SHA3-384 after the reset, with valid toggling.
        seen.delete(); seen_lb.delete(); d0 = n_done;
        begin_msg(3'd2, 11'd384);
        for (int i = 0; i < 13; i++) put(64'hF00 + 64'(i), i == 12);
        consume(13, 1'b1);
        finish_hash();
        chk("F_count", 64'(seen.size()), 64'd13);
        bad = 0;
        for (int i = 0; i < 13; i++) if (sw(i) !== 64'hF00 + 64'(i)) bad++;
        chk("F_words_bad", 64'(bad), 64'd0);
        chk("F_dones", 64'(n_done - d0), 64'd1);
        chk("F_err", 64'(err), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
